weight_loader: RTL and testbench

//  Fetches one MATRIX_WIDTH-row weight tile from the weight buffer (read port 1) and streams it,
//  row-indexed, to the matrix multiply unit's weight-load inputs. One instruction loads one tile.

---
 rtl/weight_loader.sv | 146 ++++++++++++++
 tb/tb_weight_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Streams one MATRIX_WIDTH-row weight tile from the weight buffer to the MMU weight-load port.
// It absorbs the buffer read latency and zero-pads short tiles to MATRIX_WIDTH rows.
module weight_loader #(
  parameter int MATRIX_WIDTH = 14,
  parameter int READ_LATENCY = 3,
  parameter int ADDR_WIDTH   = 8,
  parameter int ROWS_W       = $clog2(MATRIX_WIDTH + 1),
  parameter int ROW_W        = $clog2(MATRIX_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic [ADDR_WIDTH-1:0]          instr_addr,
  input  logic [ROWS_W-1:0]              instr_rows,
  input  logic                           instr_signed,
  output logic [ADDR_WIDTH-1:0]          buf_addr,
  output logic                           buf_en,
  input  logic [MATRIX_WIDTH-1:0][7:0]   buf_data,
  output logic                           weight_valid,
  output logic [MATRIX_WIDTH-1:0][7:0]   weight_data,
  output logic [ROW_W-1:0]               weight_row,
  output logic                           weight_signed,
  output logic                           weight_last,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PAD} state_t;

  state_t                         state_reg;
  logic                           ready_reg;
  logic                           buf_en_reg;
  logic [ADDR_WIDTH-1:0]          addr_reg;
  logic [ROWS_W-1:0]              rows_reg;
  logic [ROWS_W-1:0]              fetch_cnt_reg;
  logic [ROWS_W-1:0]              out_cnt_reg;
  logic                           signed_reg;
  logic [READ_LATENCY-1:0]        inflight_reg;
  logic                           valid_reg;
  logic [MATRIX_WIDTH-1:0][7:0]   data_reg;
  logic [ROW_W-1:0]               row_reg;
  logic                           last_reg;
  logic                           done_reg;

  logic              accept;
  logic              capture;
  logic              pad_emit;
  logic [ROWS_W-1:0] rows_eff;

  assign rows_eff = (instr_rows > ROWS_W'(MATRIX_WIDTH)) ? ROWS_W'(MATRIX_WIDTH) : instr_rows;
  assign instr_ready = ready_reg && (state_reg == IDLE);
  assign accept      = instr_valid && instr_ready && enable;
  assign capture     = inflight_reg[READ_LATENCY-1];
  assign pad_emit    = (state_reg == PAD) && (out_cnt_reg != ROWS_W'(MATRIX_WIDTH));

  // The buffer RAM register updates on en1 regardless of its pipeline enable, so reads must stop during a stall.
  assign buf_en        = buf_en_reg && enable;
  assign buf_addr      = addr_reg;
  assign busy          = (state_reg != IDLE);
  assign weight_valid  = valid_reg;
  assign weight_data   = data_reg;
  assign weight_row    = row_reg;
  assign weight_signed = signed_reg;
  assign weight_last   = last_reg;
  assign done          = done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b0;
      buf_en_reg    <= 1'b0;
      addr_reg      <= '0;
      rows_reg      <= '0;
      fetch_cnt_reg <= '0;
      out_cnt_reg   <= '0;
      signed_reg    <= 1'b0;
      inflight_reg  <= '0;
      valid_reg     <= 1'b0;
      data_reg      <= '0;
      row_reg       <= '0;
      last_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
      if (enable) begin
        inflight_reg <= {inflight_reg[READ_LATENCY-2:0], buf_en_reg};
        valid_reg    <= 1'b0;
        data_reg     <= '0;
        row_reg      <= '0;
        last_reg     <= 1'b0;
        done_reg     <= 1'b0;

        // Fetched rows and pad rows share one output counter, keeping row indices contiguous.
        if (capture || pad_emit) begin
          valid_reg   <= 1'b1;
          data_reg    <= capture ? buf_data : '0;
          row_reg     <= out_cnt_reg[ROW_W-1:0];
          last_reg    <= (out_cnt_reg == ROWS_W'(MATRIX_WIDTH - 1));
          out_cnt_reg <= out_cnt_reg + ROWS_W'(1);
        end

        case (state_reg)
          IDLE: begin
            if (accept) begin
              addr_reg      <= instr_addr;
              rows_reg      <= rows_eff;
              signed_reg    <= instr_signed;
              out_cnt_reg   <= '0;
              fetch_cnt_reg <= ROWS_W'(1);
              if (rows_eff == '0) begin
                state_reg <= PAD;
              end else begin
                state_reg  <= FETCH;
                buf_en_reg <= 1'b1;
              end
            end
          end
          FETCH: begin
            if (fetch_cnt_reg == rows_reg) begin
              buf_en_reg <= 1'b0;
              state_reg  <= DRAIN;
            end else begin
              addr_reg      <= addr_reg + ADDR_WIDTH'(1);
              fetch_cnt_reg <= fetch_cnt_reg + ROWS_W'(1);
            end
          end
          DRAIN: begin
            if (capture && (out_cnt_reg == rows_reg - ROWS_W'(1))) begin
              state_reg <= PAD;
            end
          end
          PAD: begin
            if (last_reg) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a latency-3 buffer model feeds the DUT and expected
// rows, buffer reads and done pulses are queued at instruction accept and checked as they appear.
module tb_weight_loader;
  localparam int MW   = 14;
  localparam int AW   = 8;
  localparam int RW   = $clog2(MW + 1);
  localparam int ROWW = $clog2(MW);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic instr_valid = 1'b0;
  logic instr_signed = 1'b0;
  logic [AW-1:0] instr_addr = '0;
  logic [RW-1:0] instr_rows = '0;
  logic instr_ready, buf_en, weight_valid, weight_signed, weight_last, busy, done;
  logic [AW-1:0] buf_addr;
  logic [MW-1:0][7:0] buf_data, weight_data;
  logic [ROWW-1:0] weight_row;

  weight_loader #(.MATRIX_WIDTH(MW), .READ_LATENCY(3), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_addr(instr_addr),
    .instr_rows(instr_rows), .instr_signed(instr_signed),
    .buf_addr(buf_addr), .buf_en(buf_en), .buf_data(buf_data),
    .weight_valid(weight_valid), .weight_data(weight_data), .weight_row(weight_row),
    .weight_signed(weight_signed), .weight_last(weight_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ROWW-1:0]    row;
    logic [MW-1:0][7:0] data;
    logic               last;
    logic               sgn;
    int                 ecyc;
  } wexp_t;
  typedef struct {
    logic [AW-1:0] addr;
    int            ecyc;
  } aexp_t;

  wexp_t wq[$];
  aexp_t aq[$];
  int    dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ecyc = 0;
  int acc_cyc = 0;
  int row0_cyc = 0;
  int done_cyc = 0;
  int n_buf_en = 0;
  int n_out = 0;

  // Weight buffer model: RAM register on en1, two pipeline registers on the shared enable.
  logic [MW-1:0][7:0] mem [256];
  logic [MW-1:0][7:0] ram_q = '0;
  logic [MW-1:0][7:0] p1 = '0;
  logic [MW-1:0][7:0] p2 = '0;
  assign buf_data = p2;

  always @(posedge clk) begin
    if (buf_en) ram_q <= mem[buf_addr];
    if (enable) begin
      p1 <= ram_q;
      p2 <= p1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst && enable) ecyc++;
    end
  end

  // Monitor: pops expectations on every enabled cycle, pushes new ones on accept.
  initial begin
    wexp_t e;
    aexp_t a;
    int    d;
    int    r;
    forever begin
      @(negedge clk);
      if (rst && !enable) begin
        checks++;
        if (buf_en !== 1'b0) begin
          errors++;
          $display("FAIL stall_buf_en: got %b expected 0", buf_en);
        end
      end else if (rst) begin
        if (buf_en) begin
          n_buf_en++;
          checks++;
          if (aq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_buf_en: got addr %h expected no read", buf_addr);
          end else begin
            a = aq.pop_front();
            if (buf_addr !== a.addr || ecyc != a.ecyc) begin
              errors++;
              $display("FAIL buf_read: got addr %h cyc %0d expected addr %h cyc %0d",
                       buf_addr, ecyc, a.addr, a.ecyc);
            end
          end
        end
        checks++;
        if (weight_valid) begin
          n_out++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_row: got row %0d expected no row", weight_row);
          end else begin
            e = wq.pop_front();
            if (weight_row == '0) row0_cyc = cyc;
            if (weight_row !== e.row || weight_data !== e.data || weight_last !== e.last ||
                weight_signed !== e.sgn || (e.ecyc >= 0 && ecyc != e.ecyc)) begin
              errors++;
              $display("FAIL row%0d: got row %0d data %h last %b sgn %b cyc %0d expected row %0d data %h last %b sgn %b cyc %0d",
                       e.row, weight_row, weight_data, weight_last, weight_signed, ecyc,
                       e.row, e.data, e.last, e.sgn, e.ecyc);
            end
          end
        end else if (weight_data !== '0 || weight_last !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: got data %h last %b expected 0 0", weight_data, weight_last);
        end
        if (done) begin
          n_out++;
          done_cyc = cyc;
          checks++;
          if (dq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got done=1 expected 0");
          end else begin
            d = dq.pop_front();
            if (d >= 0 && ecyc != d) begin
              errors++;
              $display("FAIL done_cycle: got %0d expected %0d", ecyc, d);
            end
          end
        end
        if (instr_valid && instr_ready) begin
          r = (int'(instr_rows) > MW) ? MW : int'(instr_rows);
          acc_cyc = cyc;
          for (int i = 0; i < MW; i++) begin
            e.row  = ROWW'(i);
            e.data = (i < r) ? mem[AW'(int'(instr_addr) + i)] : '0;
            e.last = (i == MW - 1);
            e.sgn  = instr_signed;
            e.ecyc = (r > 0) ? ecyc + 5 + i : -1;
            wq.push_back(e);
          end
          for (int i = 0; i < r; i++) begin
            a.addr = AW'(int'(instr_addr) + i);
            a.ecyc = ecyc + 1 + i;
            aq.push_back(a);
          end
          dq.push_back((r > 0) ? ecyc + MW + 5 : -1);
        end
      end
    end
  end

  task automatic issue(input logic [AW-1:0] a, input logic [RW-1:0] r, input logic s);
    bit ok = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b1; instr_addr = a; instr_rows = r; instr_signed = s;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (enable && instr_ready) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept: got no accept expected accept within 100 cycles");
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (!busy && !done && wq.size() == 0 && aq.size() == 0 && dq.size() == 0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: got busy=%b pending rows %0d reads %0d dones %0d expected all drained",
               busy, wq.size(), aq.size(), dq.size());
      wq.delete(); aq.delete(); dq.delete();
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    #1;
    checks++;
    if ({instr_ready, busy, done, weight_valid, buf_en, weight_last} !== 6'b0 || weight_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy %b busy %b done %b valid %b en %b data %h expected all 0",
               instr_ready, busy, done, weight_valid, buf_en, weight_data);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy %b busy %b expected 1 0", instr_ready, busy);
    end
  endtask

  task automatic test_full_tile();
    issue(8'h10, RW'(14), 1'b1);
    wait_idle();
    checks++;
    if (row0_cyc - acc_cyc != 5 || done_cyc - acc_cyc != 19) begin
      errors++;
      $display("FAIL full_timing: got row0 %0d done %0d expected 5 19", row0_cyc - acc_cyc, done_cyc - acc_cyc);
    end
  endtask

  task automatic test_short_tile();
    issue(8'h40, RW'(3), 1'b0);
    wait_idle();
    checks++;
    if (done_cyc - acc_cyc != 19) begin
      errors++;
      $display("FAIL short_done: got %0d expected 19", done_cyc - acc_cyc);
    end
    issue(8'h20, RW'(15), 1'b1);
    wait_idle();
  endtask

  task automatic test_stall();
    logic [MW*8+ROWW+AW+2:0] snap;
    issue(8'h10, RW'(14), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    snap = {weight_valid, busy, weight_data, weight_row, buf_addr, weight_last};
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({weight_valid, busy, weight_data, weight_row, buf_addr, weight_last} !== snap) begin
        errors++;
        $display("FAIL stall_hold: got %h expected %h",
                 {weight_valid, busy, weight_data, weight_row, buf_addr, weight_last}, snap);
      end
    end
    @(posedge clk); #1;
    enable = 1'b1;
    wait_idle();
    checks++;
    if (row0_cyc - acc_cyc != 9 || done_cyc - acc_cyc != 23) begin
      errors++;
      $display("FAIL stall_timing: got row0 %0d done %0d expected 9 23", row0_cyc - acc_cyc, done_cyc - acc_cyc);
    end
  endtask

  task automatic test_wrap_zero();
    int en_before;
    issue(8'hFE, RW'(3), 1'b1);
    wait_idle();
    en_before = n_buf_en;
    issue(8'h30, RW'(0), 1'b0);
    wait_idle();
    checks++;
    if (n_buf_en != en_before) begin
      errors++;
      $display("FAIL zero_rows_reads: got %0d reads expected 0", n_buf_en - en_before);
    end
  endtask

  task automatic test_back_to_back();
    int  first_acc;
    bit  ok = 1'b0;
    issue(8'h10, RW'(14), 1'b1);
    first_acc = acc_cyc;
    @(posedge clk); #1;
    instr_valid = 1'b1; instr_addr = 8'h40; instr_rows = RW'(3); instr_signed = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (enable && instr_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if (!ok || acc_cyc - first_acc != 19 || acc_cyc != done_cyc) begin
      errors++;
      $display("FAIL b2b_accept: got accept at %0d (done at %0d) expected %0d",
               acc_cyc - first_acc, done_cyc - first_acc, 19);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(8'h10, RW'(14), 1'b1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({instr_ready, busy, done, weight_valid, buf_en, weight_last} !== 6'b0 || weight_data !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy %b busy %b done %b valid %b en %b data %h expected all 0",
               instr_ready, busy, done, weight_valid, buf_en, weight_data);
    end
    wq.delete(); aq.delete(); dq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    seen = n_out;
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: got rdy %b busy %b expected 1 0", instr_ready, busy);
    end
    repeat (30) @(posedge clk);
    checks++;
    if (n_out != seen) begin
      errors++;
      $display("FAIL midreset_stale: got %0d outputs expected 0", n_out - seen);
    end
    issue(8'h40, RW'(3), 1'b1);
    wait_idle();
  endtask

  initial begin
    for (int a = 0; a < 256; a++)
      for (int j = 0; j < MW; j++)
        mem[a][j] = 8'(a * 7 + j * 13 + 1);
    for (int k = 0; k < MW; k++)
      for (int j = 0; j < MW; j++)
        mem[8'h10 + k][j] = (j == k) ? 8'h01 : 8'h00;

    test_reset();
    test_full_tile();
    test_short_tile();
    test_stall();
    test_wrap_zero();
    test_back_to_back();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
